// File: rtl/fmq_pkg.sv
// fmq_pkg
//   Shared definitions for the phase bank sequencer: opcodes, reply codes,
//   sequencer state encoding and the bit layout of a 24-bit command frame.
//   No ports; imported by cmd_deframer and phase_bank_sequencer.
package fmq_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_QUERY  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [7:0] RSP_COMMIT = 8'h01;
  localparam logic [7:0] RSP_CLEAR  = 8'h02;
  localparam logic [7:0] RSP_NAK    = 8'hFF;

  localparam int FRAME_WIDTH = 24;

  // Bit 7 of every byte is the frame sync flag, so each field is split
  // around the sync bits of bytes 1 and 2.
  localparam int OP_MSB      = 22;
  localparam int OP_LSB      = 21;
  localparam int ADDR_HI_MSB = 20;
  localparam int ADDR_HI_LSB = 16;
  localparam int ADDR_LO_MSB = 14;
  localparam int ADDR_LO_LSB = 13;
  localparam int VAL_HI_MSB  = 12;
  localparam int VAL_HI_LSB  = 8;
  localparam int VAL_LO_MSB  = 6;
  localparam int VAL_LO_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT_EDGE,
    ST_RESP
  } state_t;

  function automatic logic [1:0] frame_op(input logic [FRAME_WIDTH-1:0] f);
    return f[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [6:0] frame_addr(input logic [FRAME_WIDTH-1:0] f);
    return {f[ADDR_HI_MSB:ADDR_HI_LSB], f[ADDR_LO_MSB:ADDR_LO_LSB]};
  endfunction

  function automatic logic [11:0] frame_value(input logic [FRAME_WIDTH-1:0] f);
    return {f[VAL_HI_MSB:VAL_HI_LSB], f[VAL_LO_MSB:VAL_LO_LSB]};
  endfunction

endpackage

// File: rtl/cmd_deframer.sv
// cmd_deframer
//   Assembles three received bytes into one command frame. A byte with its
//   top bit set always starts a new frame; a byte without it is only taken
//   as a continuation byte, and is dropped when no frame has been started.
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   rx_data/valid   incoming byte stream
//   rx_ready        registered accept flag, follows enable one cycle later
//   enable          sequencer is (about to be) idle and can take bytes
//   frame           assembled frame, valid only while frame_valid is high
//   frame_valid     one-cycle pulse on the clock that accepts the last byte
module cmd_deframer
  import fmq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic                      enable,
  output logic [3*DATA_WIDTH-1:0]   frame,
  output logic                      frame_valid
);

  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] byte0;
  logic [DATA_WIDTH-1:0] byte1;
  logic                  accept;
  logic                  sync_bit;

  assign accept   = rx_valid && rx_ready;
  assign sync_bit = rx_data[DATA_WIDTH-1];

  // The final byte is passed straight through so the sequencer can leave
  // idle on the same edge that accepts it.
  assign frame       = {byte0, byte1, rx_data};
  assign frame_valid = accept && !sync_bit && (byte_idx == 2'd2);

  // Byte index and holding registers; a sync byte resynchronises at any index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= 2'd0;
      byte0    <= '0;
      byte1    <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_ready <= enable;
      if (accept) begin
        if (sync_bit) begin
          byte0    <= rx_data;
          byte_idx <= 2'd1;
        end else begin
          case (byte_idx)
            2'd1: begin
              byte1    <= rx_data;
              byte_idx <= 2'd2;
            end
            default: byte_idx <= 2'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/phase_bank_sequencer.sv
// phase_bank_sequencer
//   Executes host command frames against a shadow bank of phase offsets and
//   copies the shadow bank to the active bank on a carrier-period boundary,
//   strobing the oscillators' reload line so every channel switches together.
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   rx_data/valid/ready incoming command bytes
//   tx_data/valid/ready reply bytes, held until accepted
//   divide              oscillator half-period minus one
//   offsets             active bank, channel i at [OFFSET_WIDTH*i +: OFFSET_WIDTH]
//   reload              active-low one-cycle oscillator restart strobe
//   busy                high while a command is being processed
module phase_bank_sequencer
  import fmq_pkg::*;
#(
  parameter int OUTPUTS      = 88,
  parameter int OFFSET_WIDTH = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int DIVIDE_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           rx_data,
  input  logic                            rx_valid,
  output logic                            rx_ready,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  input  logic [DIVIDE_WIDTH-1:0]         divide,
  output logic [OFFSET_WIDTH*OUTPUTS-1:0] offsets,
  output logic                            reload,
  output logic                            busy
);

  state_t state;
  state_t next_state;

  logic [3*DATA_WIDTH-1:0] frame;
  logic                    frame_valid;
  logic [FRAME_WIDTH-1:0]  cmd;

  logic [OFFSET_WIDTH-1:0] shadow [OUTPUTS];
  logic [OFFSET_WIDTH-1:0] active [OUTPUTS];

  logic [DIVIDE_WIDTH:0] period_cnt;
  logic [DIVIDE_WIDTH:0] period_max;
  logic                  at_edge;

  logic [1:0]  cmd_op;
  logic [6:0]  cmd_addr;
  logic [11:0] cmd_value;
  logic        addr_ok;

  logic       do_write;
  logic       do_clear;
  logic       do_commit;
  logic       load_rsp;
  logic [7:0] rsp_code;

  cmd_deframer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_deframer (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .enable      (next_state == ST_IDLE),
    .frame       (frame),
    .frame_valid (frame_valid)
  );

  assign cmd_op    = frame_op(cmd);
  assign cmd_addr  = frame_addr(cmd);
  assign cmd_value = frame_value(cmd);
  assign addr_ok   = {1'b0, cmd_addr} < 8'(OUTPUTS);

  // Last count of a full carrier period is 2*divide+1. Using >= means a
  // divide that shrinks while the counter is past the new end still wraps.
  assign period_max = {divide, 1'b1};
  assign at_edge    = period_cnt >= period_max;

  assign busy = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and command dispatch.
  always_comb begin
    next_state = state;
    do_write   = 1'b0;
    do_clear   = 1'b0;
    do_commit  = 1'b0;
    load_rsp   = 1'b0;
    rsp_code   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (frame_valid) next_state = ST_EXEC;
      end
      ST_EXEC: begin
        case (cmd_op)
          OP_WRITE: begin
            if (addr_ok) begin
              do_write   = 1'b1;
              next_state = ST_IDLE;
            end else begin
              load_rsp   = 1'b1;
              rsp_code   = RSP_NAK;
              next_state = ST_RESP;
            end
          end
          OP_COMMIT: next_state = ST_WAIT_EDGE;
          OP_QUERY: begin
            load_rsp   = 1'b1;
            rsp_code   = 8'(OUTPUTS);
            next_state = ST_RESP;
          end
          default: begin
            do_clear   = 1'b1;
            load_rsp   = 1'b1;
            rsp_code   = RSP_CLEAR;
            next_state = ST_RESP;
          end
        endcase
      end
      ST_WAIT_EDGE: begin
        if (at_edge) begin
          do_commit  = 1'b1;
          load_rsp   = 1'b1;
          rsp_code   = RSP_COMMIT;
          next_state = ST_RESP;
        end
      end
      default: begin
        if (tx_ready) next_state = ST_IDLE;
      end
    endcase
  end

  // Latch the frame as it completes so EXEC sees a stable command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd <= '0;
    end else if (frame_valid) begin
      cmd <= frame;
    end
  end

  // Shadow bank takes writes and clears; active bank only changes on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OUTPUTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUTPUTS; i++) begin
        if (do_clear) begin
          shadow[i] <= '0;
        end else if (do_write && (cmd_addr == 7'(i))) begin
          shadow[i] <= OFFSET_WIDTH'(cmd_value);
        end
        if (do_commit) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  // Period counter tracks the oscillators' phase; it is held at zero while
  // reload is low because the oscillators restart on that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt <= '0;
      reload     <= 1'b1;
    end else begin
      reload <= !do_commit;
      if (do_commit || !reload || at_edge) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end

  // Reply register: loaded when a reply is produced, held until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load_rsp) begin
      tx_valid <= 1'b1;
      tx_data  <= DATA_WIDTH'(rsp_code);
    end else if ((state == ST_RESP) && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  always_comb begin
    offsets = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      offsets[OFFSET_WIDTH*i +: OFFSET_WIDTH] = active[i];
    end
  end

endmodule

// File: tb/tb_phase_bank_sequencer.sv
// tb_phase_bank_sequencer
//   Drives command frames into phase_bank_sequencer and compares replies,
//   the active offset bank and reload timing with a bank/period model.
module tb_phase_bank_sequencer;

  localparam int OUTPUTS = 88;
  localparam int OW      = 12;
  localparam int DW      = 8;
  localparam int DIVW    = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [DW-1:0]       rx_data = '0;
  logic                rx_valid = 1'b0;
  logic                rx_ready;
  logic [DW-1:0]       tx_data;
  logic                tx_valid;
  logic                tx_ready = 1'b0;
  logic [DIVW-1:0]     divide = 10'd624;
  logic [OW*OUTPUTS-1:0] offsets;
  logic                reload;
  logic                busy;

  int checks = 0;
  int failures = 0;

  logic [OW-1:0] shadow_m [OUTPUTS];
  logic [OW-1:0] active_m [OUTPUTS];

  int c_model;
  int prev_c;

  always #10 clk = ~clk;

  phase_bank_sequencer #(
    .OUTPUTS      (OUTPUTS),
    .OFFSET_WIDTH (OW),
    .DATA_WIDTH   (DW),
    .DIVIDE_WIDTH (DIVW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .divide   (divide),
    .offsets  (offsets),
    .reload   (reload),
    .busy     (busy)
  );

  // Carrier phase: counts cycles within a period of 2*(divide+1), restarting
  // on any cycle the oscillators see reload low.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_model <= 0;
      prev_c  <= 0;
    end else begin
      prev_c <= c_model;
      if (!reload || c_model >= 2 * int'(divide) + 1) c_model <= 0;
      else c_model <= c_model + 1;
    end
  end

  function automatic logic [23:0] enc(input logic [1:0] op, input int addr, input int value);
    logic [6:0]  a;
    logic [11:0] v;
    a = addr[6:0];
    v = value[11:0];
    return {1'b1, op, a[6:2], 1'b0, a[1:0], v[11:7], 1'b0, v[6:0]};
  endfunction

  function automatic logic [OW*OUTPUTS-1:0] exp_offsets();
    logic [OW*OUTPUTS-1:0] r;
    r = '0;
    for (int i = 0; i < OUTPUTS; i++) r[OW*i +: OW] = active_m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < OUTPUTS; i++) begin
      shadow_m[i] = '0;
      active_m[i] = '0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL byte_accept rx_ready=%b required=1", rx_ready);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Called right after the final byte of a frame has been accepted.
  task automatic post_frame_check(input string name);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_exec rx_ready=%b busy=%b required rx_ready=0 busy=1", name, rx_ready, busy);
    end
  endtask

  task automatic send_frame(input logic [23:0] f, input string name);
    send_byte(f[23:16]);
    send_byte(f[15:8]);
    send_byte(f[7:0]);
    post_frame_check(name);
  endtask

  task automatic expect_write_done(input string name);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_done rx_ready=%b tx_valid=%b busy=%b required 1 0 0", name, rx_ready, tx_valid, busy);
    end
  endtask

  task automatic expect_reply(input logic [7:0] code, input int hold, input string name);
    int n;
    bit stable;
    n = 0;
    stable = 1'b1;
    while (tx_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_reply_timeout tx_valid=%b required=1", name, tx_valid);
      return;
    end
    checks++;
    if (tx_data !== code) begin
      failures++;
      $display("[TB] FAIL %s_reply_data got=%h required=%h", name, tx_data, code);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== code || rx_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("[TB] FAIL %s_reply_hold tx_valid=%b tx_data=%h rx_ready=%b required 1 %h 0", name, tx_valid, tx_data, rx_ready, code);
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_reply_release tx_valid=%b busy=%b required 0 0", name, tx_valid, busy);
    end
  endtask

  // Starts at the negedge of the EXEC cycle of a COMMIT frame.
  task automatic wait_commit(input string name);
    int n;
    int lim;
    bit stable;
    n = 0;
    stable = 1'b1;
    lim = 2 * (int'(divide) + 1) + 5;
    while (reload === 1'b1 && n < lim) begin
      if (offsets !== exp_offsets()) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("[TB] FAIL %s_precommit_offsets changed before boundary", name);
    end
    checks++;
    if (reload !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_commit_timeout reload=%b required=0", name, reload);
      return;
    end
    checks++;
    if (prev_c < 2 * int'(divide) + 1 || n > 2 * (int'(divide) + 1) + 1) begin
      failures++;
      $display("[TB] FAIL %s_commit_boundary phase=%0d wait=%0d required phase>=%0d", name, prev_c, n, 2 * int'(divide) + 1);
    end
    for (int i = 0; i < OUTPUTS; i++) active_m[i] = shadow_m[i];
    checks++;
    if (offsets !== exp_offsets()) begin
      failures++;
      $display("[TB] FAIL %s_offsets got=%h required=%h", name, offsets, exp_offsets());
    end
    @(negedge clk);
    checks++;
    if (reload !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_reload_width reload=%b required=1", name, reload);
    end
    expect_reply(8'h01, 0, name);
  endtask

  task automatic do_write(input int addr, input int value, input string name);
    send_frame(enc(2'b00, addr, value), name);
    if (addr < OUTPUTS) begin
      shadow_m[addr] = value[OW-1:0];
      expect_write_done(name);
    end else begin
      expect_reply(8'hFF, 0, name);
    end
  endtask

  task automatic do_commit(input string name);
    send_frame(enc(2'b01, 0, 0), name);
    wait_commit(name);
  endtask

  task automatic do_clear(input string name);
    send_frame(enc(2'b11, 0, 0), name);
    for (int i = 0; i < OUTPUTS; i++) shadow_m[i] = '0;
    expect_reply(8'h02, 0, name);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
        reload !== 1'b1 || offsets !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values rx_ready=%b tx_valid=%b tx_data=%h busy=%b reload=%b required 0 0 00 0 1",
               rx_ready, tx_valid, tx_data, busy, reload);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release rx_ready=%b required=1", rx_ready);
    end
  endtask

  task automatic test_write_commit();
    do_write(5, 12'h123, "write_ch5");
    do_commit("commit_ch5");
  endtask

  task automatic test_nak();
    do_write(100, 12'h456, "write_nak");
    do_commit("commit_after_nak");
  endtask

  task automatic test_query_backpressure();
    send_frame(enc(2'b10, 0, 0), "query");
    expect_reply(8'(OUTPUTS), 40, "query");
  endtask

  task automatic test_resync();
    send_byte(8'h05);
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'h85);
    send_byte(8'h00);
    send_byte(8'h05);
    post_frame_check("resync");
    shadow_m[20] = 12'h005;
    expect_write_done("resync");
    do_commit("commit_resync");
  endtask

  task automatic test_clear();
    do_write(0, 12'hABC, "write_ch0");
    do_write(87, 12'hFED, "write_ch87");
    do_clear("clear");
    do_commit("commit_clear");
  endtask

  task automatic test_reset_mid_wait();
    bit quiet;
    quiet = 1'b1;
    do_write(3, 12'h777, "write_ch3");
    send_frame(enc(2'b01, 0, 0), "commit_reset");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (reload !== 1'b1 || tx_valid !== 1'b0) quiet = 1'b0;
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (reload !== 1'b1 || tx_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("[TB] FAIL reset_mid_wait_quiet reload/tx_valid toggled, required reload=1 tx_valid=0");
    end
    checks++;
    if (offsets !== '0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_wait_state busy=%b rx_ready=%b offsets_zero=%b required 0 0 1",
               busy, rx_ready, offsets == '0);
    end
    rst = 1'b1;
    @(negedge clk);
    do_write(9, 12'h321, "write_after_reset");
    do_commit("commit_after_reset");
  endtask

  task automatic test_random();
    int op;
    int addr;
    divide = 10'($urandom_range(2, 30));
    for (int k = 0; k < 30; k++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          addr = int'($urandom_range(0, 127));
          do_write(addr, int'($urandom_range(0, 4095)), "rand_write");
        end
        1: do_commit("rand_commit");
        2: begin
          send_frame(enc(2'b10, 0, 0), "rand_query");
          expect_reply(8'(OUTPUTS), int'($urandom_range(0, 3)), "rand_query");
        end
        default: do_clear("rand_clear");
      endcase
    end
    do_commit("rand_final_commit");
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_nak();
    test_query_backpressure();
    test_resync();
    test_clear();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
